// File: rtl/inputs_sa_skew.sv
// Diagonal skew stage: lane k of each accepted column is delayed k extra cycles so array rows see a wavefront.
// Latency: lane k output is registered k+1 cycles after the column is presented; o_done pulses with the last column on lane LANES-1.
// Backpressure: none, the array consumes every cycle; INPUTS_SKEW_ZP_EN adds i_zp and saturating zero-point subtraction.
module inputs_sa_skew #(
    parameter int LANES  = 9,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_clear,
    input  logic                                i_valid,
    input  logic                                i_last,
    input  logic signed [LANES-1:0][DATA_W-1:0] i_data,
`ifdef INPUTS_SKEW_ZP_EN
    input  logic signed [DATA_W-1:0]            i_zp,
`endif
    output logic signed [LANES-1:0][DATA_W-1:0] o_data,
    output logic [LANES-1:0]                    o_valid,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [CNT_W-1:0]                    o_count,
    output logic                                o_err
);

    localparam int DCW = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [DCW-1:0]               dcnt;
    logic [DCW-1:0]               dcnt_nxt;
    logic                         accept;
    logic                         err_set;
    logic [LANES-1:0][DATA_W-1:0] col_in;

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        accept    = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE, ST_STREAM: begin
                if (i_valid) begin
                    accept = 1'b1;
                    if (i_last) begin
                        state_nxt = ST_DRAIN;
                        dcnt_nxt  = DRAIN_LOAD;
                    end else begin
                        state_nxt = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                err_set = i_valid;
                // The edge that takes the counter to zero is the edge that enters DONE.
                if (dcnt <= DCW'(1)) begin
                    state_nxt = ST_DONE;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt - DCW'(1);
                end
            end
            ST_DONE: begin
                err_set   = i_valid;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            dcnt    <= '0;
            o_count <= '0;
            o_err   <= 1'b0;
        end else if (i_clear) begin
            state   <= ST_IDLE;
            dcnt    <= '0;
            o_count <= '0;
            o_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (accept && (o_count != '1)) begin
                o_count <= o_count + CNT_W'(1);
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);

`ifdef INPUTS_SKEW_ZP_EN
    logic [DATA_W:0] diff;
`endif

    always_comb begin
        col_in = '0;
`ifdef INPUTS_SKEW_ZP_EN
        diff   = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
`ifdef INPUTS_SKEW_ZP_EN
            // One extra bit holds the exact difference; top two bits disagree on overflow.
            diff = {i_data[k][DATA_W-1], i_data[k]} - {i_zp[DATA_W-1], i_zp};
            if (diff[DATA_W] != diff[DATA_W-1]) begin
                col_in[k] = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                col_in[k] = diff[DATA_W-1:0];
            end
`else
            col_in[k] = i_data[k];
`endif
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] d_sr [0:k];
        logic [k:0]        v_sr;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int j = 0; j <= k; j++) d_sr[j] <= '0;
                v_sr <= '0;
            end else if (i_clear) begin
                for (int j = 0; j <= k; j++) d_sr[j] <= '0;
                v_sr <= '0;
            end else begin
                // Bubbles enter as zero data so o_data is clean wherever o_valid is low.
                d_sr[0] <= accept ? col_in[k] : '0;
                v_sr[0] <= accept;
                for (int j = 1; j <= k; j++) begin
                    d_sr[j] <= d_sr[j-1];
                    v_sr[j] <= v_sr[j-1];
                end
            end
        end

        assign o_data[k]  = d_sr[k];
        assign o_valid[k] = v_sr[k];
    end

endmodule

// File: tb/tb_inputs_sa_skew.sv
// Scoreboard bench for inputs_sa_skew: per-lane expectations queued at drive time, checked on every falling edge.
module tb_inputs_sa_skew;
    localparam int LANES = 9;

    typedef logic signed [LANES-1:0][7:0] col_t;
    typedef struct {
        int         lane;
        int         due;
        logic [7:0] dat;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_clear;
    logic        i_valid;
    logic        i_last;
    col_t        i_data;
`ifdef INPUTS_SKEW_ZP_EN
    logic signed [7:0] i_zp;
`endif
    col_t        o_data;
    logic [LANES-1:0] o_valid;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;
    logic        o_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   e_last = 0;
    exp_t sb[$];

    inputs_sa_skew #(.LANES(LANES), .DATA_W(8), .CNT_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_data  (i_data),
`ifdef INPUTS_SKEW_ZP_EN
        .i_zp    (i_zp),
`endif
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_count (o_count),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [7:0] xf(input logic [7:0] d);
`ifdef INPUTS_SKEW_ZP_EN
        int t;
        t = int'($signed(d)) - int'(i_zp);
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return t[7:0];
`else
        return d;
`endif
    endfunction

    always @(negedge i_clk) begin
        int idx;
        for (int k = 0; k < LANES; k++) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].lane == k) begin
                    idx = i;
                    break;
                end
            end
            checks++;
            if (o_valid[k]) begin
                if (idx < 0 || sb[idx].due != cyc) begin
                    errors++;
                    $display("FAIL lane%0d_valid cyc %0d: valid high, expected due %0d", k, cyc,
                             (idx < 0) ? -1 : sb[idx].due);
                end else begin
                    if (o_data[k] !== sb[idx].dat) begin
                        errors++;
                        $display("FAIL lane%0d_data cyc %0d: got %0h want %0h", k, cyc, o_data[k], sb[idx].dat);
                    end
                    sb.delete(idx);
                end
            end else begin
                if (o_data[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL lane%0d_bubble cyc %0d: data %0h while invalid, want 0", k, cyc, o_data[k]);
                end else if (idx >= 0 && sb[idx].due <= cyc) begin
                    errors++;
                    $display("FAIL lane%0d_missing cyc %0d: no valid, want %0h due %0d", k, cyc, sb[idx].dat, sb[idx].due);
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input col_t d, input logic taken);
        i_valid = v;
        i_last  = l;
        i_data  = d;
        if (v && taken) begin
            for (int k = 0; k < LANES; k++) sb.push_back('{k, cyc + 1 + k, xf(d[k])});
        end
        tick();
        if (v && taken) e_last = cyc;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
    endtask

    task automatic do_clear;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic wait_done(output int npulse, output int dcyc, output logic vld_at, output logic busy_after);
        npulse = 0;
        dcyc = -100;
        vld_at = 1'b0;
        busy_after = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (o_done) begin
                npulse++;
                dcyc = cyc;
                vld_at = o_valid[LANES-1];
            end
            if (npulse > 0 && cyc == dcyc + 1) busy_after = o_busy;
            if (npulse > 0 && cyc > dcyc + 1) break;
            tick();
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) tick();
        checks++; if (o_valid !== '0)  begin errors++; $display("FAIL rst_valid: got %0h want 0", o_valid); end
        checks++; if (o_data !== '0)   begin errors++; $display("FAIL rst_data: got %0h want 0", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", o_done); end
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", o_count); end
        checks++; if (o_err !== 1'b0)  begin errors++; $display("FAIL rst_err: got %0b want 0", o_err); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        col_t d;
        int n, dc;
        logic va, ba;
        for (int k = 0; k < LANES; k++) d[k] = 8'(k + 1);
        drive(1'b1, 1'b1, d, 1'b1);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", o_busy); end
        wait_done(n, dc, va, ba);
        checks++; if (n != 1) begin errors++; $display("FAIL single_done_pulses: got %0d want 1", n); end
        checks++; if (dc != e_last + LANES - 1) begin errors++; $display("FAIL single_done_cyc: got %0d want %0d", dc, e_last + LANES - 1); end
        checks++; if (va !== 1'b1) begin errors++; $display("FAIL single_done_align: lane8 valid %0b want 1", va); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b want 0", ba); end
        checks++; if (o_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", o_count); end
    endtask

    task automatic test_stream20;
        col_t d;
        int n, dc;
        logic va, ba;
        do_clear();
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < LANES; k++) d[k] = 8'(c * 10 + k);
            drive(1'b1, c == 19, d, 1'b1);
        end
        wait_done(n, dc, va, ba);
        checks++; if (n != 1) begin errors++; $display("FAIL s20_done_pulses: got %0d want 1", n); end
        checks++; if (dc != e_last + LANES - 1) begin errors++; $display("FAIL s20_done_cyc: got %0d want %0d", dc, e_last + LANES - 1); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL s20_busy_after: got %0b want 0", ba); end
        checks++; if (o_count !== 16'd20) begin errors++; $display("FAIL s20_count: got %0d want 20", o_count); end
    endtask

    task automatic test_bubbles;
        col_t d;
        int n, dc;
        logic va, ba;
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < LANES; k++) d[k] = 8'(50 + i * 10 + k);
            drive(pat[i] == 1, i == 5, d, 1'b1);
        end
        wait_done(n, dc, va, ba);
        checks++; if (n != 1) begin errors++; $display("FAIL bub_done_pulses: got %0d want 1", n); end
        checks++; if (o_count !== 16'd4) begin errors++; $display("FAIL bub_count: got %0d want 4", o_count); end
    endtask

    task automatic test_err;
        col_t d;
        int n, dc;
        logic va, ba;
        do_clear();
        for (int k = 0; k < LANES; k++) d[k] = 8'(k + 20);
        drive(1'b1, 1'b1, d, 1'b1);
        drive(1'b1, 1'b0, ~d, 1'b0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_drain: got %0b want 1", o_err); end
        checks++; if (o_count !== 16'd1) begin errors++; $display("FAIL err_drain_count: got %0d want 1", o_count); end
        wait_done(n, dc, va, ba);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", o_err); end
        do_clear();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", o_err); end
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL err_clear_count: got %0d want 0", o_count); end
        i_clear = 1'b1;
        drive(1'b1, 1'b0, d, 1'b0);
        i_clear = 1'b0;
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL clr_prio_count: got %0d want 0", o_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clr_prio_busy: got %0b want 0", o_busy); end
        drive(1'b1, 1'b1, d, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (o_done) break;
            tick();
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL err_done_wait: done %0b want 1", o_done); end
        drive(1'b1, 1'b0, ~d, 1'b0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_in_done: got %0b want 1", o_err); end
        checks++; if (o_count !== 16'd1) begin errors++; $display("FAIL err_in_done_count: got %0d want 1", o_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL err_idle_after: busy %0b want 0", o_busy); end
        do_clear();
    endtask

    task automatic test_reset_mid;
        col_t d;
        int n, dc;
        logic va, ba;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < LANES; k++) d[k] = 8'(c * 16 + k + 3);
            drive(1'b1, 1'b0, d, 1'b1);
        end
        i_rst = 1'b1;
        #2;
        sb.delete();
        checks++; if (o_valid !== '0) begin errors++; $display("FAIL mid_rst_valid: got %0h want 0", o_valid); end
        checks++; if (o_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %0h want 0", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", o_busy); end
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", o_count); end
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < LANES; k++) d[k] = 8'(100 - k);
        drive(1'b1, 1'b1, d, 1'b1);
        wait_done(n, dc, va, ba);
        checks++; if (dc != e_last + LANES - 1) begin errors++; $display("FAIL mid_rst_done_cyc: got %0d want %0d", dc, e_last + LANES - 1); end
        checks++; if (o_count !== 16'd1) begin errors++; $display("FAIL mid_rst_count2: got %0d want 1", o_count); end
    endtask

`ifdef INPUTS_SKEW_ZP_EN
    task automatic test_zp;
        col_t d;
        int n, dc;
        logic va, ba;
        do_clear();
        i_zp = -8'sd100;
        for (int k = 0; k < LANES; k++) d[k] = 8'd100;
        drive(1'b1, 1'b0, d, 1'b1);
        i_zp = 8'sd100;
        for (int k = 0; k < LANES; k++) d[k] = 8'h9C;
        drive(1'b1, 1'b0, d, 1'b1);
        i_zp = 8'sd3;
        for (int k = 0; k < LANES; k++) d[k] = 8'd10;
        drive(1'b1, 1'b1, d, 1'b1);
        wait_done(n, dc, va, ba);
        checks++; if (o_count !== 16'd3) begin errors++; $display("FAIL zp_count: got %0d want 3", o_count); end
        i_zp = '0;
    endtask
`endif

    initial begin
        i_rst   = 1'b1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
`ifdef INPUTS_SKEW_ZP_EN
        i_zp    = '0;
`endif
        test_reset();
        test_single();
        test_stream20();
        test_bubbles();
        test_err();
        test_reset_mid();
`ifdef INPUTS_SKEW_ZP_EN
        test_zp();
`endif
        repeat (12) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected lane outputs never seen, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inputs_sa_skew.md
# inputs_sa_skew

Diagonal skew stage between the im2col input feeder and the systolic array. Each cycle it accepts one 9-element signed 8-bit window column from the feeder. It delays lane k by k cycles so that the array rows receive operands in wavefront order. When the feeder marks the final column of a channel, the block drains its delay lines and pulses a completion flag.

## Interface
Parameters:
- LANES, 9, number of lanes; equals the array row count.
- DATA_W, 8, signed element width.
- CNT_W, 16, width of the accepted-vector counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- i_clear  in  1  synchronous clear; same effect as reset, at the next edge.
- i_valid  in  1  i_data holds a new column this cycle; driven from the feeder's started/valid flag.
- i_last  in  1  qualified by i_valid; marks the final column of the current channel.
- i_data  in  LANES x DATA_W signed  window column; element k feeds lane k.
- i_zp  in  DATA_W signed  input zero point. Present only when INPUTS_SKEW_ZP_EN is defined.
- o_data  out  LANES x DATA_W signed  skewed operands to the array rows.
- o_valid  out  LANES  per-lane valid.
- o_busy  out  1  a stream or drain is in progress.
- o_done  out  1  one-cycle pulse: the last column has left lane LANES-1.
- o_count  out  CNT_W  columns accepted since the last reset or clear; saturates at all-ones.
- o_err  out  1  sticky: a column arrived while in DRAIN or DONE.

## Operation
- Lane structure:
  - Each lane k is a register chain of depth k+1, carrying data and valid bits.
  - Lane 0 is a single output register.
  - An accepted column enters stage 0 of every lane at the same edge.
- Bubbles: a cycle in STREAM with i_valid=0 inserts data=0, valid=0 into every lane. o_data is 0 wherever o_valid is 0.
- States:
  - IDLE:
    - i_valid=1 → accept the column, go to STREAM.
    - If i_last is also 1, go directly to DRAIN.
  - STREAM:
    - i_valid=1 accepts a column.
    - i_valid=1 with i_last=1 → DRAIN; load the drain counter with LANES-1.
  - DRAIN:
    - Counter decrements each edge; at 0 → DONE.
    - i_valid=1 here drops the column and sets o_err. o_count is not incremented.
  - DONE: one cycle → IDLE. i_valid=1 here is also dropped and sets o_err.
- o_busy = (state != IDLE).
- o_count increments on every accepted column and holds at 2^CNT_W-1.
- Reset or clear, mid-operation included:
  - All lane registers, o_valid, o_data, o_count, o_err and the drain counter go to 0.
  - State returns to IDLE.
  - i_clear takes priority over i_valid in the same cycle.

## Timing
- The column accepted at edge E appears on lane k from edge E+k. Lane 0 latency is 1 cycle; lane LANES-1 latency is LANES cycles.
- o_valid[k] at edge E+k mirrors i_valid at edge E.
- Last column accepted at edge E0:
  - DRAIN is held from E0 to E0+LANES-1.
  - o_done is high for the single cycle after edge E0+LANES-1, coinciding with o_valid[LANES-1] for that column.
  - The state is IDLE after edge E0+LANES.
- A new stream may begin at the first IDLE cycle, so back-to-back channels have a LANES-cycle gap.
- Reset values: o_data=0, o_valid=0, o_busy=0, o_done=0, o_count=0, o_err=0.
- No backpressure: the array must accept every cycle.

## Configuration
- Macro INPUTS_SKEW_ZP_EN:
  - Defined: the i_zp port exists. Each element is replaced by sat(i_data[k] - i_zp) before stage 0, saturating to [-128, 127]. The subtraction is computed at 9 bits and adds no latency.
  - Undefined: no i_zp port; elements pass through unmodified.

## Test plan
- Reset, then i_valid=1 for 1 cycle with i_data[k]=k+1 and i_last=1 → o_data[k]=k+1 with o_valid[k]=1 exactly at edge E+k; o_done pulses once, aligned with lane 8; o_count=1.
- 20 consecutive columns (column n, lane k = n*10+k), last marked on n=19 → each lane is a contiguous valid run of 20 with skew k; o_count=20; o_busy falls one cycle after o_done.
- Stream with i_valid pattern 1,0,1,1,0,1 → the zero/invalid bubbles appear on every lane, shifted by k; no data corruption.
- i_valid=1 during DRAIN → column dropped, o_err=1 (sticky), o_count unchanged; i_clear resets o_err to 0.
- Assert i_rst mid-stream after 5 columns → all outputs are 0 immediately (asynchronous); the next stream starts cleanly from IDLE.
- With INPUTS_SKEW_ZP_EN and i_zp=-100:
  - i_data[0]=100 → 127 (saturated).
  - i_zp=100, i_data[1]=-100 → -128 (saturated).
  - i_zp=3, i_data[2]=10 → 7.
